// File: rtl/fsab_rr_scheduler.sv
// Round-robin grant scheduler for the FSAB outbound bus: one start pulse per transaction, credit gated.
// Latency: pending request with credit in IDLE -> grant_start the next cycle; holds grant until the last beat.
module fsab_rr_scheduler #(
  parameter int FSAB_DEVICES = 4,
  parameter int LEN_W        = 4,
  parameter int CREDITS_W    = 4,
  parameter int INIT_CREDITS = 8,
  parameter int TIMEOUT_CYC  = 255,
  localparam int IDX_W       = (FSAB_DEVICES > 1) ? $clog2(FSAB_DEVICES) : 1,
  localparam int IC_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic [FSAB_DEVICES-1:0]       req_pending,
  input  logic [FSAB_DEVICES-1:0]       req_is_wr,
  input  logic [FSAB_DEVICES*LEN_W-1:0] req_lens,
  input  logic                          bus_valid,
  input  logic                          fsabo_credit,
  output logic [FSAB_DEVICES-1:0]       grant_start,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          grant_busy,
  output logic [CREDITS_W-1:0]          credits,
  output logic                          err_overflow,
  output logic                          err_timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [FSAB_DEVICES-1:0] grant_start_q, grant_start_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]        last_idx_q, last_idx_d;
  logic [CREDITS_W-1:0]    credits_q, credits_d;
  logic [LEN_W-1:0]        beats_left_q, beats_left_d;
  logic [IC_W-1:0]         idle_cnt_q, idle_cnt_d;
  logic                    err_overflow_q, err_overflow_d;
  logic                    err_timeout_q, err_timeout_d;

  logic                    found;
  logic [IDX_W-1:0]        winner;
  logic [FSAB_DEVICES-1:0] win_oh;
  logic                    win_wr;
  logic [LEN_W-1:0]        win_len;
  logic                    grant_fire;

  // Search order starts one past the previous winner so every requester gets its turn.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    win_oh  = '0;
    win_wr  = 1'b0;
    win_len = '0;
    for (int k = 1; k <= FSAB_DEVICES; k++) begin
      for (int i = 0; i < FSAB_DEVICES; i++) begin
        if (!found && req_pending[i] && (((int'(last_idx_q) + k) % FSAB_DEVICES) == i)) begin
          found     = 1'b1;
          winner    = IDX_W'(i);
          win_oh[i] = 1'b1;
          win_wr    = req_is_wr[i];
          win_len   = req_lens[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_start_d = '0;
    grant_idx_d   = grant_idx_q;
    last_idx_d    = last_idx_q;
    beats_left_d  = beats_left_q;
    idle_cnt_d    = idle_cnt_q;
    err_timeout_d = err_timeout_q;
    grant_fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && (credits_q != '0)) begin
          grant_fire    = 1'b1;
          grant_start_d = win_oh;
          grant_idx_d   = winner;
          last_idx_d    = winner;
          state_d       = BUSY;
          idle_cnt_d    = '0;
          beats_left_d  = (win_wr && (win_len != '0)) ? win_len : LEN_W'(1);
        end
      end
      BUSY: begin
        if (bus_valid) begin
          idle_cnt_d   = '0;
          beats_left_d = beats_left_q - LEN_W'(1);
          if (beats_left_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end else begin
          // Saturate so a stuck transaction cannot wrap the counter.
          if (idle_cnt_q != IC_W'(TIMEOUT_CYC)) begin
            idle_cnt_d = idle_cnt_q + IC_W'(1);
          end
          if (idle_cnt_d == IC_W'(TIMEOUT_CYC)) begin
            err_timeout_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credits_d      = credits_q;
    err_overflow_d = err_overflow_q;
    if (fsabo_credit && !grant_fire) begin
      if (credits_q == {CREDITS_W{1'b1}}) begin
        err_overflow_d = 1'b1;
      end else begin
        credits_d = credits_q + CREDITS_W'(1);
      end
    end else if (!fsabo_credit && grant_fire) begin
      credits_d = credits_q - CREDITS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= IDLE;
      grant_start_q  <= '0;
      grant_idx_q    <= '0;
      last_idx_q     <= IDX_W'(FSAB_DEVICES - 1);
      credits_q      <= CREDITS_W'(INIT_CREDITS);
      beats_left_q   <= '0;
      idle_cnt_q     <= '0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_start_q  <= grant_start_d;
      grant_idx_q    <= grant_idx_d;
      last_idx_q     <= last_idx_d;
      credits_q      <= credits_d;
      beats_left_q   <= beats_left_d;
      idle_cnt_q     <= idle_cnt_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign grant_start  = grant_start_q;
  assign grant_idx    = grant_idx_q;
  assign grant_busy   = (state_q == BUSY);
  assign credits      = credits_q;
  assign err_overflow = err_overflow_q;
  assign err_timeout  = err_timeout_q;

endmodule
